spike_aer_encoder: RTL

//  Downstream of the time-multiplexed LIF neuron array: samples its 8-bit spike vector once per

---
 rtl/spike_aer_encoder_pkg.sv | 34 +++
 rtl/spike_aer_encoder_if.sv | 14 +
 rtl/spike_aer_encoder_fifo.sv | 58 +++++
 rtl/spike_aer_encoder.sv | 107 ++++++++++
 4 files changed

// File: rtl/spike_aer_encoder_pkg.sv
// Shared constants, AER event word layout and the lowest-set-bit helper.
package spike_aer_encoder_pkg;

  localparam int unsigned N_NEURONS  = 8;
  localparam int unsigned ADDR_W     = $clog2(N_NEURONS);
  localparam int unsigned TS_W       = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DROP_W     = 8;

  // One address-event: neuron index in the upper bits, timestep below.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TS_W-1:0]   ts;
  } aer_event_t;

  localparam int unsigned EVENT_W = $bits(aer_event_t);

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [ADDR_W-1:0] lsb_index(input logic [N_NEURONS-1:0] v);
    logic [ADDR_W-1:0] idx;
    logic              found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (v[i] && !found) begin
        idx   = ADDR_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Valid/ready AER event port toward the chip I/O.
interface spike_aer_encoder_if
  import spike_aer_encoder_pkg::*;
();

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [TS_W-1:0]   ts;

  modport master (output valid, output addr, output ts, input ready);
  modport slave  (input valid, input addr, input ts, output ready);

endinterface

// File: rtl/spike_aer_encoder_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module aer_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   not_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count_next;

  // Head entry is always presented; caller only pops when not_empty.
  assign dout = mem[rd_ptr];

  // Occupancy bookkeeping; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage, pointers and registered occupancy/empty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      not_empty <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count     <= count_next;
      not_empty <= (count_next != '0);
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Samples spike vectors per timestep, serialises set bits into AER events via a FIFO,
// and counts vectors dropped while the previous one is still being encoded.
module spike_aer_encoder
  import spike_aer_encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  spike_aer_encoder_if.master  aer,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_cnt,
  input  logic                 clr_ovf
);

  logic [TS_W-1:0]      ts_cnt;
  logic [N_NEURONS-1:0] pending;
  logic [TS_W-1:0]      pend_ts;

  logic [N_NEURONS-1:0] pending_next;
  logic [DROP_W-1:0]    drop_cnt_next;
  logic                 overflow_next;
  logic                 capture;
  logic                 drop;
  logic                 can_push;
  logic                 push;
  logic                 pop;
  logic                 fifo_valid;
  aer_event_t           push_ev;
  aer_event_t           head_ev;

  assign capture  = spike_valid & spike_ready;
  assign drop     = spike_valid & ~spike_ready;
  assign pop      = fifo_valid & aer.ready;
  assign can_push = (fifo_count < CNT_W'(FIFO_DEPTH)) | pop;
  assign push     = (pending != '0) & can_push;

  assign aer.valid = fifo_valid;
  assign aer.addr  = head_ev.addr;
  assign aer.ts    = head_ev.ts;

  // Event for the lowest pending neuron, tagged with the vector's timestep.
  always_comb begin
    push_ev      = '0;
    push_ev.addr = lsb_index(pending);
    push_ev.ts   = pend_ts;
  end

  // Pending vector refill/clear and loss accounting.
  always_comb begin
    pending_next  = pending;
    overflow_next = overflow;
    drop_cnt_next = drop_cnt;
    if (capture) begin
      pending_next = spike_in;
    end else if (push) begin
      pending_next = pending & (pending - N_NEURONS'(1));
    end
    if (drop) begin
      overflow_next = 1'b1;
      if (clr_ovf) begin
        drop_cnt_next = DROP_W'(1);
      end else if (drop_cnt != {DROP_W{1'b1}}) begin
        drop_cnt_next = drop_cnt + DROP_W'(1);
      end
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
      drop_cnt_next = '0;
    end
  end

  // Timestep counter, pending register and sticky loss state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt      <= '0;
      pending     <= '0;
      pend_ts     <= '0;
      spike_ready <= 1'b1;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (spike_valid) ts_cnt <= ts_cnt + TS_W'(1);
      if (capture) pend_ts <= ts_cnt;
      pending     <= pending_next;
      spike_ready <= (pending_next == '0);
      overflow    <= overflow_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

  aer_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .din       (push_ev),
    .pop       (pop),
    .dout      (head_ev),
    .count     (fifo_count),
    .not_empty (fifo_valid)
  );

endmodule
